ucode_sequencer: RTL and testbench

//  Parametrised microcode sequencer for the TTL RISC-V core; next generation of the fixed-table control unit.

---
 rtl/ucode_pkg.sv | 62 ++++++
 rtl/ucode_ram.sv | 27 ++
 rtl/ucode_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_ucode_sequencer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ucode_pkg.sv
// Shared definitions for the microcode sequencer: where the sequencer fields
// sit inside a control word, width helpers and the quiet value of the
// per-cycle sequencer flags.
package ucode_pkg;

    // Number of control-word bits the sequencer uses for itself (the top bits).
    localparam int N_SEQ_FIELDS = 5;

    // What the sequencer does this cycle. The order follows the decision priority.
    typedef enum logic [2:0] {
        ACT_IDLE,    // sequencer disabled
        ACT_TRAP,    // abort current instruction
        ACT_STALL,   // waiting on memory
        ACT_BRANCH,  // branch-resolve step
        ACT_RETIRE,  // last step of the instruction
        ACT_INC,     // move to the next microstep
        ACT_HOLD     // commit, stay on this step
    } seq_action_e;

    // Per-cycle strobes towards the datapath.
    typedef struct packed {
        logic advance;
        logic br_not_taken;
        logic retire;
        logic trap_ack;
    } seq_flags_t;

    // Nothing commits, nothing retires, no trap acknowledged.
    localparam seq_flags_t FLAGS_IDLE = '0;

    // Sequencer field bit positions as functions of the control-word width.
    function automatic int bit_state_inc(input int cw);
        return cw - 1;
    endfunction

    function automatic int bit_state_reset(input int cw);
        return cw - 2;
    endfunction

    function automatic int bit_branch(input int cw);
        return cw - 3;
    endfunction

    function automatic int bit_subtable(input int cw);
        return cw - 4;
    endfunction

    function automatic int bit_wait_mem(input int cw);
        return cw - 5;
    endfunction

    // Number of bits that reach the datapath.
    function automatic int ctrl_w(input int cw);
        return cw - N_SEQ_FIELDS;
    endfunction

    // Microstep counter width.
    function automatic int step_w(input int steps);
        return (steps < 2) ? 1 : $clog2(steps);
    endfunction

endpackage

// File: rtl/ucode_ram.sv
// Microcode storage: one synchronous write port and one asynchronous read port.
// The contents are not reset; software loads the table before running.
module ucode_ram #(
    parameter int W     = 32,
    parameter int DEPTH = 256,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [W-1:0]  i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [W-1:0]  o_rdata
);

    logic [W-1:0] r_mem [DEPTH];

    // Write lands at the clock edge, so a same-cycle read still sees the old word.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/ucode_sequencer.sv
// Microcode sequencer: looks up the control word for {opcode,step}, optionally
// merges a func3-selected sub-table word, and steps through the microprogram
// with memory stalls, branch resolution, trap abort and retire counting.
module ucode_sequencer
    import ucode_pkg::*;
#(
    parameter int CW        = 32,
    parameter int STEPS     = 8,
    parameter int OPC_W     = 5,
    parameter int SUB_W     = 3,
    parameter int INSTRET_W = 64,
    localparam int SW       = step_w(STEPS)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic [OPC_W-1:0]     opcode,
    input  logic [SUB_W-1:0]     func3,
    input  logic                 cond,
    input  logic                 mem_ready,
    input  logic                 trap_in,
    input  logic                 prog_we,
    input  logic                 prog_sel,
    input  logic [OPC_W+SW-1:0]  prog_addr,
    input  logic [CW-1:0]        prog_data,
    output logic [CW-6:0]        ctrl,
    output logic [SW-1:0]        step,
    output logic                 advance,
    output logic                 br_not_taken,
    output logic                 retire,
    output logic                 trap_ack,
    output logic                 ucode_err,
    output logic [INSTRET_W-1:0] instret
);

    localparam int B_INC     = bit_state_inc(CW);
    localparam int B_RESET   = bit_state_reset(CW);
    localparam int B_BRANCH  = bit_branch(CW);
    localparam int B_SUB     = bit_subtable(CW);
    localparam int B_WAIT    = bit_wait_mem(CW);
    localparam int CTRL_W    = ctrl_w(CW);
    localparam int MAIN_AW   = OPC_W + SW;
    localparam int SUB_AW    = SUB_W + SW;
    localparam logic [SW-1:0] STEP_LAST = SW'(STEPS - 1);

    logic [SW-1:0]        r_step;
    logic [INSTRET_W-1:0] r_instret;
    logic                 r_ucode_err;

    logic [CW-1:0]        w_main_word;
    logic [CW-1:0]        w_sub_word;
    logic [CW-1:0]        w_word;
    seq_action_e          w_action;
    seq_flags_t           w_flags;
    logic [CTRL_W-1:0]    w_ctrl;
    logic [SW-1:0]        w_step_next;
    logic                 w_err_set;

    ucode_ram #(.W(CW), .DEPTH(2 ** MAIN_AW)) u_main_ram (
        .clk     (clk),
        .i_we    (prog_we && !prog_sel),
        .i_waddr (prog_addr),
        .i_wdata (prog_data),
        .i_raddr ({opcode, r_step}),
        .o_rdata (w_main_word)
    );

    ucode_ram #(.W(CW), .DEPTH(2 ** SUB_AW)) u_sub_ram (
        .clk     (clk),
        .i_we    (prog_we && prog_sel),
        .i_waddr (prog_addr[SUB_AW-1:0]),
        .i_wdata (prog_data),
        .i_raddr ({func3, r_step}),
        .o_rdata (w_sub_word)
    );

    // The sub-table only addresses with the low index bits; the rest are ignored.
    generate
        if (OPC_W > SUB_W) begin : g_addr_hi
            logic w_unused_addr_hi;
            assign w_unused_addr_hi = ^prog_addr[MAIN_AW-1:SUB_AW];
        end
    endgenerate

    assign w_word = w_main_word | (w_main_word[B_SUB] ? w_sub_word : '0);

    // Pick this cycle's action in priority order.
    always_comb begin
        w_action = ACT_HOLD;
        if (!enable) begin
            w_action = ACT_IDLE;
        end else if (trap_in) begin
            w_action = ACT_TRAP;
        end else if (w_word[B_WAIT] && !mem_ready) begin
            w_action = ACT_STALL;
        end else if (w_word[B_BRANCH]) begin
            w_action = ACT_BRANCH;
        end else if (w_word[B_RESET]) begin
            w_action = ACT_RETIRE;
        end else if (w_word[B_INC]) begin
            w_action = ACT_INC;
        end
    end

    // Turn the action into datapath strobes, next step and error flag.
    always_comb begin
        w_flags     = FLAGS_IDLE;
        w_ctrl      = w_word[CTRL_W-1:0];
        w_step_next = r_step;
        w_err_set   = 1'b0;
        case (w_action)
            ACT_IDLE: begin
                w_ctrl      = '0;
                w_step_next = '0;
            end
            ACT_TRAP: begin
                w_ctrl           = '0;
                w_flags.trap_ack = 1'b1;
                w_step_next      = '0;
            end
            ACT_STALL: begin
                w_step_next = r_step;
            end
            ACT_BRANCH: begin
                w_flags.advance = 1'b1;
                if (cond) begin
                    w_step_next = r_step + SW'(1);
                end else begin
                    w_step_next          = '0;
                    w_flags.br_not_taken = 1'b1;
                    w_flags.retire       = 1'b1;
                end
            end
            ACT_RETIRE: begin
                w_flags.advance = 1'b1;
                w_flags.retire  = 1'b1;
                w_step_next     = '0;
            end
            ACT_INC: begin
                w_flags.advance = 1'b1;
                if (r_step != STEP_LAST) begin
                    w_step_next = r_step + SW'(1);
                end else begin
                    // Running off the end of the microprogram is a table bug.
                    w_step_next = '0;
                    w_err_set   = 1'b1;
                end
            end
            default: begin
                w_flags.advance = 1'b1;
            end
        endcase
    end

    // Step counter, retire counter and sticky microcode error.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_step      <= '0;
            r_instret   <= '0;
            r_ucode_err <= 1'b0;
        end else begin
            r_step <= w_step_next;
            if (w_flags.retire) begin
                r_instret <= r_instret + INSTRET_W'(1);
            end
            if (w_err_set) begin
                r_ucode_err <= 1'b1;
            end
        end
    end

    assign ctrl         = w_ctrl;
    assign step         = r_step;
    assign advance      = w_flags.advance;
    assign br_not_taken = w_flags.br_not_taken;
    assign retire       = w_flags.retire;
    assign trap_ack     = w_flags.trap_ack;
    assign ucode_err    = r_ucode_err;
    assign instret      = r_instret;

endmodule

// File: tb/tb_ucode_sequencer.sv
// Bench for ucode_sequencer: loads small microprograms, then runs a vector
// table through a scoreboard queue, followed by hand-written corner cases.
module tb_ucode_sequencer;

    localparam logic [31:0] F_INC  = 32'h8000_0000;
    localparam logic [31:0] F_RST  = 32'h4000_0000;
    localparam logic [31:0] F_BR   = 32'h2000_0000;
    localparam logic [31:0] F_SUB  = 32'h1000_0000;
    localparam logic [31:0] F_WAIT = 32'h0800_0000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [4:0]  opcode;
    logic [2:0]  func3;
    logic        cond;
    logic        mem_ready;
    logic        trap_in;
    logic        prog_we;
    logic        prog_sel;
    logic [7:0]  prog_addr;
    logic [31:0] prog_data;
    logic [26:0] ctrl;
    logic [2:0]  step;
    logic        advance;
    logic        br_not_taken;
    logic        retire;
    logic        trap_ack;
    logic        ucode_err;
    logic [63:0] instret;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        en;
        logic [4:0]  op;
        logic [2:0]  f3;
        logic        cnd;
        logic        mr;
        logic        trp;
        logic [26:0] ctrl;
        logic        adv;
        logic        bnt;
        logic        ret;
        logic        tack;
        logic [2:0]  st;
        logic [63:0] ir;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];

    ucode_sequencer dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .opcode       (opcode),
        .func3        (func3),
        .cond         (cond),
        .mem_ready    (mem_ready),
        .trap_in      (trap_in),
        .prog_we      (prog_we),
        .prog_sel     (prog_sel),
        .prog_addr    (prog_addr),
        .prog_data    (prog_data),
        .ctrl         (ctrl),
        .step         (step),
        .advance      (advance),
        .br_not_taken (br_not_taken),
        .retire       (retire),
        .trap_ack     (trap_ack),
        .ucode_err    (ucode_err),
        .instret      (instret)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before the end of the test");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic en, input logic [4:0] op, input logic [2:0] f3,
                       input logic cnd, input logic mr, input logic trp,
                       input logic [26:0] c, input logic adv, input logic bnt,
                       input logic ret, input logic tack, input logic [2:0] st,
                       input logic [63:0] ir);
        vec_t v;
        v.en = en; v.op = op; v.f3 = f3; v.cnd = cnd; v.mr = mr; v.trp = trp;
        v.ctrl = c; v.adv = adv; v.bnt = bnt; v.ret = ret; v.tack = tack;
        v.st = st; v.ir = ir;
        vecs.push_back(v);
    endtask

    task automatic prog(input logic sel, input logic [7:0] addr, input logic [31:0] data);
        @(negedge clk);
        prog_we   = 1'b1;
        prog_sel  = sel;
        prog_addr = addr;
        prog_data = data;
        @(posedge clk);
        #1;
        prog_we = 1'b0;
    endtask

    initial begin
        vec_t v;
        vec_t e;
        reset_n = 1'b0; enable = 1'b0; opcode = '0; func3 = '0; cond = 1'b0;
        mem_ready = 1'b1; trap_in = 1'b0; prog_we = 1'b0; prog_sel = 1'b0;
        prog_addr = '0; prog_data = '0;

        // ---- reset state ----
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_step", 64'(step), 64'd0);
        chk("reset_instret", instret, 64'd0);
        chk("reset_err", 64'(ucode_err), 64'd0);
        reset_n = 1'b1;

        // ---- microcode load (sequencer disabled) ----
        prog(1'b0, {5'h0D, 3'd0}, F_INC | 32'h1);
        prog(1'b0, {5'h0D, 3'd1}, F_RST | 32'h3);
        prog(1'b0, {5'h01, 3'd0}, F_INC | 32'h10);
        prog(1'b0, {5'h01, 3'd1}, F_WAIT | F_INC | 32'h20);
        prog(1'b0, {5'h01, 3'd2}, F_RST | 32'h30);
        prog(1'b0, {5'h02, 3'd0}, F_INC | 32'h100);
        prog(1'b0, {5'h02, 3'd1}, F_BR | 32'h200);
        prog(1'b0, {5'h02, 3'd2}, F_RST | 32'h300);
        for (int k = 0; k < 3; k++) begin
            prog(1'b0, {5'h03, 3'(k)}, F_INC | (32'h1000 + 32'(k)));
        end
        prog(1'b0, {5'h03, 3'd3}, F_RST | 32'h1003);
        prog(1'b0, {5'h04, 3'd0}, F_SUB | F_RST | 32'h8);
        prog(1'b1, {2'b00, 3'd2, 3'd0}, 32'h40);
        prog(1'b1, {2'b00, 3'd5, 3'd0}, 32'h0);
        prog(1'b0, {5'h06, 3'd0}, 32'h77);
        for (int k = 0; k < 8; k++) begin
            prog(1'b0, {5'h05, 3'(k)}, F_INC | 32'h5);
        end

        // ---- vector table: en op f3 cond mr trap | ctrl adv bnt ret tack step instret ----
        // lui-style: fetch step then retire step
        add(1, 5'h0D, 0, 0, 1, 0, 27'h1,    1, 0, 0, 0, 3'd0, 64'd0);
        add(1, 5'h0D, 0, 0, 1, 0, 27'h3,    1, 0, 1, 0, 3'd1, 64'd0);
        // memory wait-states: three stall cycles then completion
        add(1, 5'h01, 0, 0, 1, 0, 27'h10,   1, 0, 0, 0, 3'd0, 64'd1);
        add(1, 5'h01, 0, 0, 0, 0, 27'h20,   0, 0, 0, 0, 3'd1, 64'd1);
        add(1, 5'h01, 0, 0, 0, 0, 27'h20,   0, 0, 0, 0, 3'd1, 64'd1);
        add(1, 5'h01, 0, 0, 0, 0, 27'h20,   0, 0, 0, 0, 3'd1, 64'd1);
        add(1, 5'h01, 0, 0, 1, 0, 27'h20,   1, 0, 0, 0, 3'd1, 64'd1);
        add(1, 5'h01, 0, 0, 1, 0, 27'h30,   1, 0, 1, 0, 3'd2, 64'd1);
        // branch not taken
        add(1, 5'h02, 0, 0, 1, 0, 27'h100,  1, 0, 0, 0, 3'd0, 64'd2);
        add(1, 5'h02, 0, 0, 1, 0, 27'h200,  1, 1, 1, 0, 3'd1, 64'd2);
        // branch taken
        add(1, 5'h02, 0, 1, 1, 0, 27'h100,  1, 0, 0, 0, 3'd0, 64'd3);
        add(1, 5'h02, 0, 1, 1, 0, 27'h200,  1, 0, 0, 0, 3'd1, 64'd3);
        add(1, 5'h02, 0, 1, 1, 0, 27'h300,  1, 0, 1, 0, 3'd2, 64'd3);
        // trap at step 3 of a 4-step op
        add(1, 5'h03, 0, 0, 1, 0, 27'h1000, 1, 0, 0, 0, 3'd0, 64'd4);
        add(1, 5'h03, 0, 0, 1, 0, 27'h1001, 1, 0, 0, 0, 3'd1, 64'd4);
        add(1, 5'h03, 0, 0, 1, 0, 27'h1002, 1, 0, 0, 0, 3'd2, 64'd4);
        add(1, 5'h03, 0, 0, 1, 1, 27'h0,    0, 0, 0, 1, 3'd3, 64'd4);
        add(1, 5'h03, 0, 0, 1, 0, 27'h1000, 1, 0, 0, 0, 3'd0, 64'd4);
        // disable mid-instruction
        add(0, 5'h03, 0, 0, 1, 0, 27'h0,    0, 0, 0, 0, 3'd1, 64'd4);
        // sub-table merge
        add(1, 5'h04, 2, 0, 1, 0, 27'h48,   1, 0, 1, 0, 3'd0, 64'd4);
        add(1, 5'h04, 5, 0, 1, 0, 27'h08,   1, 0, 1, 0, 3'd0, 64'd5);
        // word without sequencer fields holds the step
        add(1, 5'h06, 0, 0, 1, 0, 27'h77,   1, 0, 0, 0, 3'd0, 64'd6);
        add(1, 5'h06, 0, 0, 1, 0, 27'h77,   1, 0, 0, 0, 3'd0, 64'd6);
        add(0, 5'h06, 0, 0, 1, 0, 27'h0,    0, 0, 0, 0, 3'd0, 64'd6);
        // step overflow: STATE_INC all the way through step 7
        for (int k = 0; k < 8; k++) begin
            add(1, 5'h05, 0, 0, 1, 0, 27'h5, 1, 0, 0, 0, 3'(k), 64'd6);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            @(negedge clk);
            enable = v.en; opcode = v.op; func3 = v.f3; cond = v.cnd;
            mem_ready = v.mr; trap_in = v.trp;
            exp_q.push_back(v);
            #2;
            e = exp_q.pop_front();
            chk($sformatf("v%0d_ctrl", i),    64'(ctrl),         64'(e.ctrl));
            chk($sformatf("v%0d_advance", i), 64'(advance),      64'(e.adv));
            chk($sformatf("v%0d_bnt", i),     64'(br_not_taken), 64'(e.bnt));
            chk($sformatf("v%0d_retire", i),  64'(retire),       64'(e.ret));
            chk($sformatf("v%0d_trap_ack", i),64'(trap_ack),     64'(e.tack));
            chk($sformatf("v%0d_step", i),    64'(step),         64'(e.st));
            chk($sformatf("v%0d_instret", i), instret,           e.ir);
            chk($sformatf("v%0d_err", i),     64'(ucode_err),    64'd0);
            $display("vec %0d op=%0h step=%0d ctrl=%0h adv=%0b ret=%0b instret=%0d",
                     i, v.op, step, ctrl, advance, retire, instret);
        end
        trap_in = 1'b0;

        // ---- overflow left the error set and the step wrapped ----
        @(negedge clk);
        enable = 1'b0;
        #2;
        chk("ovf_err_set", 64'(ucode_err), 64'd1);
        chk("ovf_step_wrap", 64'(step), 64'd0);
        chk("ovf_no_retire", instret, 64'd6);
        $display("overflow: err=%0b step=%0d instret=%0d", ucode_err, step, instret);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("err_sticky", 64'(ucode_err), 64'd1);
        $display("sticky: err=%0b", ucode_err);

        // ---- write while running: old word this cycle, new word next cycle ----
        @(negedge clk);
        enable = 1'b1; opcode = 5'h06;
        prog_we = 1'b1; prog_sel = 1'b0; prog_addr = {5'h06, 3'd0}; prog_data = 32'h55;
        #2;
        chk("prog_old_word", 64'(ctrl), 64'h77);
        @(negedge clk);
        prog_we = 1'b0;
        #2;
        chk("prog_new_word", 64'(ctrl), 64'h55);
        chk("prog_step_held", 64'(step), 64'd0);
        $display("prog while enabled: ctrl=%0h step=%0d", ctrl, step);

        // ---- asynchronous reset mid-instruction ----
        @(negedge clk);
        opcode = 5'h0D;
        @(negedge clk);
        #2;
        chk("pre_reset_step", 64'(step), 64'd1);
        chk("pre_reset_ctrl", 64'(ctrl), 64'h3);
        chk("pre_reset_instret", instret, 64'd6);
        #1;
        reset_n = 1'b0;
        #1;
        chk("async_reset_step", 64'(step), 64'd0);
        chk("async_reset_err", 64'(ucode_err), 64'd0);
        chk("async_reset_instret", instret, 64'd0);
        chk("async_reset_ctrl", 64'(ctrl), 64'h1);
        $display("async reset: step=%0d err=%0b instret=%0d", step, ucode_err, instret);
        @(negedge clk);
        enable = 1'b0;
        reset_n = 1'b1;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
